// File: rtl/fifo_resp_unpack.sv
// Splits 128-bit load responses into 64-bit elements in request order.
// Optional mshrid check: define FIFO_RESP_UNPACK_MSHR_CHECK_EN.
module fifo_resp_unpack #(
  parameter int META_DEPTH = 4,
  parameter int MSHRID_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                meta_valid_i,
  output logic                meta_ready_o,
  input  logic                meta_offset_i,
  input  logic [1:0]          meta_count_i,
  input  logic [MSHRID_W-1:0] meta_mshrid_i,
  input  logic                ld_resp_valid_i,
  output logic                ld_resp_ready_o,
  input  logic [127:0]        ld_resp_data_i,
  input  logic [MSHRID_W-1:0] ld_resp_mshrid_i,
  output logic                data_valid_o,
  input  logic                data_ready_i,
  output logic [63:0]         data_o,
  output logic                mshr_err_o
);

  localparam int PTR_W = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
  localparam int OCC_W = $clog2(META_DEPTH) + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state_q;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [OCC_W-1:0] occ_q;
  logic [127:0]     line_q;
  logic             idx_q;
  logic [1:0]       rem_q;

  logic             meta_off_q [META_DEPTH];
  logic [1:0]       meta_cnt_q [META_DEPTH];

  logic             push, pop, data_hs, meta_nonempty;
  logic [1:0]       cnt_sat, cnt_eff;
  logic [PTR_W-1:0] head_nxt, tail_nxt;

  assign meta_nonempty   = (occ_q != '0);
  assign meta_ready_o    = (occ_q != OCC_W'(META_DEPTH));
  assign push            = meta_valid_i && meta_ready_o;
  assign ld_resp_ready_o = meta_nonempty &&
                           ((state_q == IDLE) ||
                            ((state_q == EMIT) && (rem_q == 2'd1) && data_ready_i));
  assign pop             = ld_resp_valid_i && ld_resp_ready_o;
  assign data_valid_o    = (state_q == EMIT);
  assign data_hs         = data_valid_o && data_ready_i;
  assign data_o          = idx_q ? line_q[127:64] : line_q[63:0];

  assign head_nxt = (head_q == PTR_W'(META_DEPTH - 1)) ? '0 : head_q + 1'b1;
  assign tail_nxt = (tail_q == PTR_W'(META_DEPTH - 1)) ? '0 : tail_q + 1'b1;

  // count 3 saturates to 2; an upper-half start can only yield one element
  always_comb begin
    cnt_sat = (meta_cnt_q[head_q] == 2'd3) ? 2'd2 : meta_cnt_q[head_q];
    cnt_eff = (meta_off_q[head_q] && cnt_sat == 2'd2) ? 2'd1 : cnt_sat;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      meta_off_q[tail_q] <= meta_offset_i;
      meta_cnt_q[tail_q] <= meta_count_i;
    end
  end

`ifdef FIFO_RESP_UNPACK_MSHR_CHECK_EN
  logic [MSHRID_W-1:0] meta_mshrid_q [META_DEPTH];
  logic                err_q;

  always_ff @(posedge clk) begin
    if (push) meta_mshrid_q[tail_q] <= meta_mshrid_i;
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (pop && (ld_resp_mshrid_i != meta_mshrid_q[head_q]))
      err_q <= 1'b1;
  end

  assign mshr_err_o = err_q;
`else
  logic unused_mshrid;
  assign unused_mshrid = ^{meta_mshrid_i, ld_resp_mshrid_i};
  assign mshr_err_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      line_q  <= '0;
      idx_q   <= 1'b0;
      rem_q   <= 2'd0;
    end else begin
      if (push) tail_q <= tail_nxt;
      if (pop)  head_q <= head_nxt;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase

      // a response accepted with the final element takes over the line registers
      if (pop) begin
        line_q  <= ld_resp_data_i;
        idx_q   <= meta_off_q[head_q];
        rem_q   <= cnt_eff;
        state_q <= (cnt_eff != 2'd0) ? EMIT : IDLE;
      end else if (data_hs) begin
        idx_q <= ~idx_q;
        rem_q <= rem_q - 2'd1;
        if (rem_q == 2'd1) state_q <= IDLE;
      end
    end
  end

endmodule
